// File: rtl/serial_bus_pkg.sv
// Shared types and helpers for the framed serial register-file slave.
// State encoding, read/write flag values and a constant-safe clog2.
package serial_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RW,
        ST_IDX,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Never returns less than 1 so derived vectors stay legal.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_slave_regfile_if.sv
// Serial bus, status and parallel load/read signals of one slave.
// The master side is the bus owner / test harness.
interface serial_slave_regfile_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 2
);
    logic              FRAME;
    logic              RX;
    logic              TX;
    logic              TX_OE;
    logic              MATCH;
    logic              BUSY;
    logic              WR_STB;
    logic              ERR;
    logic              LD_EN;
    logic [IDX_W-1:0]  LD_IDX;
    logic [DATA_W-1:0] LD_DATA;
    logic [IDX_W-1:0]  RD_IDX;
    logic [DATA_W-1:0] RD_DATA;

    modport master (
        output FRAME, RX, LD_EN, LD_IDX, LD_DATA, RD_IDX,
        input  TX, TX_OE, MATCH, BUSY, WR_STB, ERR, RD_DATA
    );

    modport slave (
        input  FRAME, RX, LD_EN, LD_IDX, LD_DATA, RD_IDX,
        output TX, TX_OE, MATCH, BUSY, WR_STB, ERR, RD_DATA
    );
endinterface

// File: rtl/serial_shift_reg.sv
// LSB-first shift register: new bits enter at the MSB, q[0] leaves first.
// Clear beats parallel load, which beats shift.
module serial_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    input  logic         sin,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= W'({sin, q} >> 1);
        end
    end
endmodule

// File: rtl/serial_slave_regfile.sv
// Addressed serial slave fronting a small register file; many instances
// share RX/FRAME and only the matching one drives TX.
module serial_slave_regfile
    import serial_bus_pkg::*;
#(
    parameter int               ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] DEV_ADDR = ADDR_W'(8'h1A),
    parameter int               DATA_W   = 8,
    parameter int               DEPTH    = 4
) (
    input logic                CLK,
    input logic                RST_N,
    serial_slave_regfile_if.slave bus
);
    localparam int IDX_W = clog2(DEPTH);
    localparam int CAP_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_M = (CAP_W > IDX_W) ? CAP_W : IDX_W;
    localparam int CNT_W = clog2(CNT_M);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] IDX_LAST  = CNT_W'(IDX_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [IDX_W:0]   DEPTH_V   = (IDX_W + 1)'(DEPTH);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               rw, rw_n;
    logic [IDX_W-1:0]   idx, idx_n, idx_nx;
    logic               match, match_n;
    logic               tx_oe, tx_oe_n;
    logic               wr_stb, wr_stb_n;
    logic               err, err_n;
    logic               cap_sh, tx_ld, tx_sh, reg_we, abort;
    logic [CAP_W-1:0]   cap_q, cap_nx;
    logic [DATA_W-1:0]  tx_q, tx_val, rd_val;
    logic [DATA_W-1:0]  regs [DEPTH];

    assign abort  = !bus.FRAME;
    assign cap_nx = CAP_W'({bus.RX, cap_q} >> 1);
    assign idx_nx = IDX_W'({bus.RX, idx} >> 1);

    serial_shift_reg #(.W(CAP_W)) u_cap (
        .clk(CLK), .rst_n(RST_N), .clr(1'b0), .load(1'b0),
        .load_val('0), .shift(cap_sh), .sin(bus.RX), .q(cap_q)
    );

    serial_shift_reg #(.W(DATA_W)) u_tx (
        .clk(CLK), .rst_n(RST_N), .clr(abort), .load(tx_ld),
        .load_val(tx_val), .shift(tx_sh), .sin(1'b0), .q(tx_q)
    );

    always_comb begin
        tx_val = '0;
        for (int k = 0; k < DEPTH; k++)
            if (idx_nx == IDX_W'(k)) tx_val = regs[k];
    end

    always_comb begin
        rd_val = '0;
        for (int k = 0; k < DEPTH; k++)
            if (bus.RD_IDX == IDX_W'(k)) rd_val = regs[k];
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rw_n     = rw;
        idx_n    = idx;
        match_n  = match;
        tx_oe_n  = tx_oe;
        wr_stb_n = 1'b0;
        err_n    = 1'b0;
        cap_sh   = 1'b0;
        tx_ld    = 1'b0;
        tx_sh    = 1'b0;
        reg_we   = 1'b0;
        if (abort) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            tx_oe_n = 1'b0;
            match_n = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    cap_sh  = 1'b1;
                    cnt_n   = CNT_W'(1);
                    state_n = ST_ADDR;
                end
                ST_ADDR: begin
                    cap_sh = 1'b1;
                    cnt_n  = cnt + 1'b1;
                    if (cnt == ADDR_LAST) begin
                        cnt_n = '0;
                        if (cap_nx[CAP_W-1 -: ADDR_W] == DEV_ADDR) begin
                            state_n = ST_RW;
                            match_n = 1'b1;
                        end else begin
                            state_n = ST_IGNORE;
                        end
                    end
                end
                ST_RW: begin
                    rw_n    = bus.RX;
                    cnt_n   = '0;
                    state_n = ST_IDX;
                end
                ST_IDX: begin
                    idx_n = idx_nx;
                    cnt_n = cnt + 1'b1;
                    if (cnt == IDX_LAST) begin
                        cnt_n = '0;
                        if ({1'b0, idx_nx} >= DEPTH_V) begin
                            err_n   = 1'b1;
                            state_n = ST_IGNORE;
                        end else if (rw == RW_READ) begin
                            tx_ld   = 1'b1;
                            tx_oe_n = 1'b1;
                            state_n = ST_RDATA;
                        end else begin
                            state_n = ST_WDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    cap_sh = 1'b1;
                    cnt_n  = cnt + 1'b1;
                    if (cnt == DATA_LAST) begin
                        cnt_n    = '0;
                        reg_we   = 1'b1;
                        wr_stb_n = 1'b1;
                        state_n  = ST_IGNORE;
                    end
                end
                ST_RDATA: begin
                    tx_sh = 1'b1;
                    cnt_n = cnt + 1'b1;
                    if (cnt == DATA_LAST) begin
                        cnt_n   = '0;
                        tx_oe_n = 1'b0;
                        state_n = ST_IGNORE;
                    end
                end
                ST_IGNORE: ;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            rw     <= RW_WRITE;
            idx    <= '0;
            match  <= 1'b0;
            tx_oe  <= 1'b0;
            wr_stb <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rw     <= rw_n;
            idx    <= idx_n;
            match  <= match_n;
            tx_oe  <= tx_oe_n;
            wr_stb <= wr_stb_n;
            err    <= err_n;
        end
    end

    // Serial commit is written last so it overrides a same-index load.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (bus.LD_EN && bus.LD_IDX == IDX_W'(k))
                    regs[k] <= bus.LD_DATA;
                if (reg_we && idx == IDX_W'(k))
                    regs[k] <= cap_nx[CAP_W-1 -: DATA_W];
            end
        end
    end

    assign bus.TX      = tx_oe & tx_q[0];
    assign bus.TX_OE   = tx_oe;
    assign bus.MATCH   = match;
    assign bus.BUSY    = (state != ST_IDLE);
    assign bus.WR_STB  = wr_stb;
    assign bus.ERR     = err;
    assign bus.RD_DATA = rd_val;
endmodule
